// File: rtl/acq_stream_mux.sv
// ---------------------------------------------------------------------------
// acq_stream_mux
//
// Acquisition input stage. It selects one of N_SRC pre-synchronised sample
// streams and extends each sample to the accumulator width, sign- or
// zero-extending per stream. It then decimates by 2^k, either by picking the
// first sample of each group or by averaging the group (floor of sum / 2^k).
// The decimated samples go out as a framed stream of n_samples outputs, or as
// an endless stream when n_samples = 0.
//
// Ports
//   clk          block clock
//   reset_n      asynchronous active-low reset
//   enable       global enable; low while running aborts the frame
//   start        single-cycle frame start request (honoured in IDLE only)
//   src_sel      stream index to acquire
//   src_signed   per-stream flag, 1 = two's complement, 0 = unsigned
//   mode         0 = pick first sample of each group, 1 = average the group
//   decim_log2   decimation exponent k (clamped to MAX_DECIM_LOG2)
//   n_samples    outputs per frame, 0 = continuous
//   in_data      packed samples, stream i at [i*IN_W +: IN_W]
//   in_valid     per-stream sample strobe
//   out_data     decimated, extended sample
//   out_valid    out_data qualifier (one cycle per group)
//   out_last     final sample of a frame
//   busy         frame in progress
//   done         one-cycle pulse after normal frame completion
//   cfg_err      one-cycle pulse when a start names a missing stream
//   sample_count outputs emitted in the current frame
// ---------------------------------------------------------------------------
module acq_stream_mux #(
    parameter int N_SRC          = 4,
    parameter int IN_W           = 14,
    parameter int OUT_W          = 32,
    parameter int MAX_DECIM_LOG2 = 8,
    parameter int SEL_W          = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    start,
    input  logic [SEL_W-1:0]        src_sel,
    input  logic [N_SRC-1:0]        src_signed,
    input  logic                    mode,
    input  logic [3:0]              decim_log2,
    input  logic [31:0]             n_samples,
    input  logic [N_SRC*IN_W-1:0]   in_data,
    input  logic [N_SRC-1:0]        in_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic [31:0]             sample_count
);

    // The accumulator holds 2^MAX_DECIM_LOG2 full-scale samples, so it cannot overflow.
    localparam int ACC_W = IN_W + MAX_DECIM_LOG2;
    localparam int GRP_W = (MAX_DECIM_LOG2 > 0) ? MAX_DECIM_LOG2 : 1;
    localparam logic [3:0] K_MAX = 4'(MAX_DECIM_LOG2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Frame configuration captured at start
    logic [SEL_W-1:0]          sel_q;
    logic                      mode_q;
    logic                      sgn_q;
    logic [3:0]                k_q;
    logic [31:0]               nsamp_q;

    // Accumulation stage
    logic [GRP_W-1:0]          grp_cnt_p0;
    logic signed [ACC_W-1:0]   acc_p0;
    logic signed [ACC_W-1:0]   hold_p0;

    // Output stage
    logic [OUT_W-1:0]          out_data_p1;
    logic                      vld_p1;
    logic                      last_p1;
    logic                      busy_q;
    logic                      done_q;
    logic                      cfg_err_q;
    logic [31:0]               sample_count_q;

    // Combinational datapath
    logic [IN_W-1:0]           sel_sample;
    logic                      sel_valid;
    logic                      start_sgn;
    logic                      sel_ok;
    logic                      go;
    logic                      reject;
    logic                      accept;
    logic                      grp_last;
    logic                      emit;
    logic                      frame_end;
    logic [31:0]               grp_mask;
    logic [31:0]               count_next;
    logic [3:0]                k_start;
    logic signed [ACC_W-1:0]   ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   res;

    // Widen a raw input sample to accumulator width.
    function automatic logic signed [ACC_W-1:0] extend_in(input logic [IN_W-1:0] v,
                                                          input logic sgn);
        if (sgn)
            extend_in = ACC_W'($signed(v));
        else
            extend_in = $signed(ACC_W'(v));
    endfunction

    // Divide a group sum by 2^k rounding toward -inf. An if/else is used
    // instead of ?: so that the signed branch keeps its arithmetic shift.
    function automatic logic signed [ACC_W-1:0] avg_shift(input logic signed [ACC_W-1:0] s,
                                                          input logic [3:0] k,
                                                          input logic sgn);
        if (sgn)
            avg_shift = s >>> k;
        else
            avg_shift = $signed($unsigned(s) >> k);
    endfunction

    // Extend or truncate an accumulator-width result to the output width.
    function automatic logic [OUT_W-1:0] fit_out(input logic signed [ACC_W-1:0] v,
                                                 input logic sgn);
        if (sgn)
            fit_out = OUT_W'(v);
        else
            fit_out = OUT_W'($unsigned(v));
    endfunction

    // Select the stream and signed flag with loops, so that an out-of-range
    // index reads zero instead of indexing past the ports.
    always_comb begin
        sel_sample = '0;
        sel_valid  = 1'b0;
        start_sgn  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (32'(sel_q) == 32'(i)) begin
                sel_sample = in_data[i*IN_W +: IN_W];
                sel_valid  = in_valid[i];
            end
            if (32'(src_sel) == 32'(i))
                start_sgn = src_signed[i];
        end
    end

    always_comb begin
        sel_ok     = (32'(src_sel) < 32'(N_SRC));
        go         = (state == IDLE) && start && enable && sel_ok;
        reject     = (state == IDLE) && start && enable && !sel_ok;
        k_start    = (32'(decim_log2) > 32'(MAX_DECIM_LOG2)) ? K_MAX : decim_log2;

        // Abort takes effect in the same cycle: no sample is accepted while
        // enable is low, so a group cannot complete on the aborting edge.
        accept     = (state == RUN) && enable && sel_valid;
        grp_mask   = (32'd1 << k_q) - 32'd1;
        grp_last   = (32'(grp_cnt_p0) == grp_mask);
        emit       = accept && grp_last;

        ext        = extend_in(sel_sample, sgn_q);
        sum        = acc_p0 + ext;
        // With k = 0 the group is one sample and the held value is stale, so
        // the current sample is taken directly.
        if (mode_q)
            res = avg_shift(sum, k_q, sgn_q);
        else if (grp_cnt_p0 == '0)
            res = ext;
        else
            res = hold_p0;

        count_next = sample_count_q + 32'd1;
        frame_end  = emit && (nsamp_q != 32'd0) && (count_next == nsamp_q);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (go) state_next = RUN;
            RUN: begin
                if (!enable)
                    state_next = IDLE;
                else if (frame_end)
                    state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q          <= '0;
            mode_q         <= 1'b0;
            sgn_q          <= 1'b0;
            k_q            <= '0;
            nsamp_q        <= '0;
            grp_cnt_p0     <= '0;
            acc_p0         <= '0;
            hold_p0        <= '0;
            out_data_p1    <= '0;
            vld_p1         <= 1'b0;
            last_p1        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            sample_count_q <= '0;
        end else begin
            if (go) begin
                sel_q   <= src_sel;
                mode_q  <= mode;
                sgn_q   <= start_sgn;
                k_q     <= k_start;
                nsamp_q <= n_samples;
            end

            // ---- accumulation stage (p0) ----
            // Anything outside RUN discards the partial group.
            if (state != RUN) begin
                grp_cnt_p0 <= '0;
                acc_p0     <= '0;
            end else if (accept) begin
                if (grp_cnt_p0 == '0)
                    hold_p0 <= ext;
                if (grp_last) begin
                    grp_cnt_p0 <= '0;
                    acc_p0     <= '0;
                end else begin
                    grp_cnt_p0 <= grp_cnt_p0 + GRP_W'(1);
                    acc_p0     <= sum;
                end
            end

            // ---- output stage (p1) ----
            vld_p1    <= emit;
            last_p1   <= frame_end;
            cfg_err_q <= reject;
            // busy covers the cycle that carries the final sample. It drops
            // together with the done pulse.
            busy_q    <= (state_next != IDLE);
            done_q    <= (state == DONE);
            if (emit)
                out_data_p1 <= fit_out(res, sgn_q);
            if (go)
                sample_count_q <= '0;
            else if (emit)
                sample_count_q <= count_next;
        end
    end

    assign out_data     = out_data_p1;
    assign out_valid    = vld_p1;
    assign out_last     = last_p1;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign sample_count = sample_count_q;

endmodule

// File: doc/acq_stream_mux.md
Name: acq_stream_mux

Overview:
Parametrised successor to the acquisition input stage. It takes N_SRC already-synchronised input sample streams (simulated source, high-speed ADC channels, embedded ADC, ...), each with its own valid strobe. It selects one stream, sign- or zero-extends it, and decimates it by 2^k using either pick or block-average. It emits a framed stream of a programmed length, with a last marker and a done pulse, to downstream processing.

Parameters:
N_SRC, 4, number of input streams
IN_W, 14, input sample width per stream
OUT_W, 32, output sample width (must be >= IN_W)
MAX_DECIM_LOG2, 8, maximum decimation exponent
SEL_W, 2, width of src_sel (must satisfy 2^SEL_W >= N_SRC)

Ports:
clk  in  1  block clock; all inputs are synchronous to it
reset_n  in  1  asynchronous active-low reset
enable  in  1  global enable; deassertion aborts a frame
start  in  1  single-cycle frame start request
src_sel  in  SEL_W  stream index to acquire
src_signed  in  N_SRC  per-stream flag: 1 = two's complement, 0 = unsigned
mode  in  1  0 = pick (first sample of each group), 1 = average
decim_log2  in  4  decimation exponent k; group size is 2^k
n_samples  in  32  output samples per frame; 0 = continuous
in_data  in  N_SRC*IN_W  packed samples; stream i occupies [i*IN_W +: IN_W]
in_valid  in  N_SRC  per-stream sample strobe
out_data  out  OUT_W  decimated, extended sample
out_valid  out  1  out_data qualifier
out_last  out  1  marks the final sample of a frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse at normal frame completion
cfg_err  out  1  one-cycle pulse when a start is rejected
sample_count  out  32  outputs emitted in the current frame

Behaviour:
- Reset (asynchronous, reset_n = 0) forces every output to 0, the state to IDLE, and all counters and the accumulator to 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when start=1, enable=1 and src_sel < N_SRC.
  - On that transition, latch src_sel, mode, n_samples, src_signed[src_sel] and k = min(decim_log2, MAX_DECIM_LOG2).
  - Clear sample_count, the group counter and the accumulator.
  - busy = 1 from the next cycle.
- start=1, enable=1 and src_sel >= N_SRC in IDLE: no transition; cfg_err = 1 for exactly the next cycle.
- start in RUN or DONE is ignored. Config input changes during RUN are ignored because the latched copies are used.
- RUN, sample accept: a sample is accepted on any cycle where in_valid[latched sel] = 1. Valids on other streams are ignored.
- RUN, extension: each accepted sample is extended to ACC_W = IN_W + MAX_DECIM_LOG2. Sign-extend if the latched signed flag is set, otherwise zero-extend.
- RUN, group counter: counts 0 .. 2^k - 1 and wraps to 0 on the sample that completes a group.
- Pick mode: hold the extended sample accepted at group count 0. Output it when the group completes.
- Average mode: accumulate all 2^k extended samples. Output is sum >> k: arithmetic shift if signed, logical if unsigned, i.e. truncation toward -inf. The accumulator cannot overflow.
- Output width: the result is extended (sign or zero, as above) or truncated to OUT_W.
- Output timing: out_valid = 1 for exactly one cycle, in the cycle after the in_valid that completes a group (latency 1). On that output sample_count increments.
  - The next group's first sample may arrive in that same output cycle and is accepted normally. Back-to-back in_valid every cycle is supported at full rate.
- Frame end: when n_samples != 0 and the output being emitted is number n_samples, out_last = 1 on that same cycle and the state goes to DONE.
  - DONE lasts one cycle: done = 1, busy = 0 from that cycle, then the state returns to IDLE.
  - With n_samples = 0 the frame never ends and sample_count wraps at 2^32 with no marker.
- Abort: enable = 0 while in RUN returns the state to IDLE on the next edge.
  - The partial group is discarded.
  - No out_valid, out_last or done is generated.
  - sample_count holds its last value.
  - An output already registered in that cycle still completes.
- k = 0: every accepted sample is output, in both modes.
- Reset mid-frame: outputs are cleared immediately, with no partial output.
- No backpressure: downstream must accept at out_valid rate.

Test Plan:
- Pick, k=0, n_samples=4, src_sel=1 unsigned, in_data[1] = 10,11,12,13 on consecutive cycles -> out_data 10,11,12,13 at latency 1; out_last with 13; done the next cycle; busy 0.
- Pick, k=2, n_samples=2, samples 1..8 every cycle -> outputs 1 and 5; out_last on 5.
- Average, k=2, signed stream, samples -4,-4,-4,-8 -> out_data 0xFFFFFFFB (-5). Same test unsigned with 16383 x4 -> 0x00003FFF.
- Continuous (n_samples=0), enable dropped after 3 outputs mid-group -> no further out_valid, no out_last/done, busy 0, sample_count 3. A restart then produces a fresh frame starting with sample_count = 1.
- start with src_sel=3 while N_SRC=3 -> cfg_err pulses 1 cycle, busy stays 0. Toggling in_valid on a non-selected stream during RUN -> no outputs.
- reset_n low mid-frame for 1 cycle -> all outputs 0 immediately, state IDLE. decim_log2=15 with MAX=8 -> group size 256.
